// File: rtl/convolutor_rom_reader_pkg.sv
// Shared types and constants for the coefficient ROM read sequencer.
package convolutor_rom_reader_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} rd_state_t;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned BUF_CNTW  = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/convolutor_skid_fifo.sv
// Two-entry FIFO that absorbs ROM read latency; entry 0 is always the head.
module convolutor_skid_fifo
   import convolutor_rom_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push_i,
   input  logic [WIDTH-1:0]    push_data_i,
   input  logic                pop_i,
   output logic [WIDTH-1:0]    head_o,
   output logic [BUF_CNTW-1:0] count_o
);

   logic [WIDTH-1:0]    mem0_q, mem0_d;
   logic [WIDTH-1:0]    mem1_q, mem1_d;
   logic [BUF_CNTW-1:0] count_q, count_d;

   always_comb begin
      mem0_d  = mem0_q;
      mem1_d  = mem1_q;
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (count_q == BUF_CNTW'(0)) mem0_d = push_data_i;
            else                         mem1_d = push_data_i;
            count_d = count_q + BUF_CNTW'(1);
         end
         2'b01: begin
            mem0_d  = mem1_q;
            count_d = count_q - BUF_CNTW'(1);
         end
         2'b11: begin
            // Simultaneous push and pop: occupancy unchanged, queue shifts.
            if (count_q == BUF_CNTW'(1)) begin
               mem0_d = push_data_i;
            end else begin
               mem0_d = mem1_q;
               mem1_d = push_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem0_q  <= '0;
         mem1_q  <= '0;
         count_q <= '0;
      end else begin
         mem0_q  <= mem0_d;
         mem1_q  <= mem1_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem0_q;
   assign count_o = count_q;

endmodule

// File: rtl/convolutor_rom_reader.sv
// Fetches a wrapping run of ROM words and streams them out on valid/ready,
// hiding the one-cycle ROM latency behind a two-entry buffer.
module convolutor_rom_reader
   import convolutor_rom_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned ADDRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [ADDRW-1:0] base_addr_i,
   input  logic [ADDRW:0]   length_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [ADDRW-1:0] rom_addr_o,
   input  logic [WIDTH-1:0] rom_data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             last_o
);

   localparam int unsigned CNTW = ADDRW + 1;

   rd_state_t           state_q, state_d;
   logic [CNTW-1:0]     len_q, len_d;
   logic [CNTW-1:0]     issue_cnt_q, issue_cnt_d;
   logic [CNTW-1:0]     out_cnt_q, out_cnt_d;
   logic [ADDRW-1:0]    rom_addr_q, rom_addr_d;
   logic                inflight_q, inflight_d;
   logic [BUF_CNTW-1:0] fifo_count;
   logic [BUF_CNTW-1:0] occ_c;
   logic                credit_c;
   logic                issue_c;
   logic                pop_c;

   convolutor_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (rom_data_i),
      .pop_i       (pop_c),
      .head_o      (data_o),
      .count_o     (fifo_count)
   );

   // A read may only be issued if its word is guaranteed a buffer slot.
   assign pop_c    = valid_o & ready_i;
   assign occ_c    = fifo_count + BUF_CNTW'(inflight_q);
   assign credit_c = (occ_c < BUF_CNTW'(BUF_DEPTH)) ||
                     ((occ_c == BUF_CNTW'(BUF_DEPTH)) && pop_c);
   assign issue_c  = (state_q == FETCH) && (issue_cnt_q < len_q) && credit_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // rom_addr_q always holds the address of the next read to issue.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      out_cnt_d   = out_cnt_q;
      rom_addr_d  = rom_addr_q;
      inflight_d  = issue_c;
      if (issue_c) begin
         issue_cnt_d = issue_cnt_q + CNTW'(1);
         if (issue_cnt_d < len_q) rom_addr_d = rom_addr_q + ADDRW'(1);
      end
      if (pop_c) out_cnt_d = out_cnt_q + CNTW'(1);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d       = length_i;
               issue_cnt_d = '0;
               out_cnt_d   = '0;
               if (length_i != CNTW'(0)) begin
                  rom_addr_d = base_addr_i;
                  state_d    = FETCH;
               end else begin
                  state_d    = DONE;
               end
            end
         end
         FETCH:   if (issue_cnt_d == len_q) state_d = DRAIN;
         DRAIN:   if (out_cnt_d == len_q)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= '0;
         issue_cnt_q <= '0;
         out_cnt_q   <= '0;
         rom_addr_q  <= '0;
         inflight_q  <= 1'b0;
      end else begin
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         out_cnt_q   <= out_cnt_d;
         rom_addr_q  <= rom_addr_d;
         inflight_q  <= inflight_d;
      end
   end

   always_comb begin
      busy_o     = (state_q != IDLE);
      done_o     = (state_q == DONE);
      valid_o    = (fifo_count != BUF_CNTW'(0));
      last_o     = valid_o && (out_cnt_q == len_q - CNTW'(1));
      rom_addr_o = rom_addr_q;
   end

endmodule

// File: tb/tb_convolutor_rom_reader.sv
// Scoreboard bench for convolutor_rom_reader with a behavioural 1-cycle ROM.
module tb_convolutor_rom_reader;
   import convolutor_rom_reader_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned ADDRW = 4;

   logic             clk;
   logic             rst_n;
   logic             start_i;
   logic [ADDRW-1:0] base_addr_i;
   logic [ADDRW:0]   length_i;
   logic             busy_o;
   logic             done_o;
   logic [ADDRW-1:0] rom_addr_o;
   logic [WIDTH-1:0] rom_data_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             ready_i;
   logic             last_o;

   convolutor_rom_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .length_i    (length_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rom_addr_o  (rom_addr_o),
      .rom_data_i  (rom_data_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .last_o      (last_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH-1:0] rom [DEPTH];
   always @(posedge clk) rom_data_i <= rom[rom_addr_o];

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } exp_t;

   exp_t exp_q[$];
   int   addr_log[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int busy_cnt = 0, valid_cnt = 0, done_cnt = 0, hs_cnt = 0;
   int done_cyc = -1, first_valid_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1;
   int start_cyc = 0;
   int max_cnt = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   logic             prev_last = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: pops expected words on every handshake and checks hold rules.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy_o)  busy_cnt++;
         if (valid_o) valid_cnt++;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (prev_stall) begin
            check("hold_valid", int'(valid_o), 1);
            check("hold_data", int'(data_o), int'(prev_data));
            check("hold_last", int'(last_o), int'(prev_last));
         end
         if (valid_o && ready_i) begin
            hs_cnt++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", data_o, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("stream_data", int'(data_o), int'(e.data));
               check("stream_last", int'(last_o), int'(e.last));
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = data_o;
         prev_last  = last_o;
         if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic start_xfer(input int base, input int len);
      for (int i = 0; i < len; i++) begin
         exp_t e;
         e.data = WIDTH'(8'h10 + ((base + i) % DEPTH));
         e.last = (i == len - 1);
         exp_q.push_back(e);
      end
      first_valid_cyc = -1;
      first_hs_cyc    = -1;
      addr_log.delete();
      @(posedge clk); #1;
      start_i     = 1'b1;
      base_addr_i = ADDRW'(base);
      length_i    = (ADDRW + 1)'(len);
      @(posedge clk); #1;
      start_i     = 1'b0;
      start_cyc   = cyc;
   endtask

   // Waits for a done pulse, optionally toggling ready in a fixed pattern.
   task automatic wait_done(input string name, input int d0, input bit bp);
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int k = 0;
      bit seen = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (done_cnt > d0) begin
            seen = 1'b1;
            break;
         end
         if (busy_o && (addr_log.size() == 0 || addr_log[$] != int'(rom_addr_o)))
            addr_log.push_back(int'(rom_addr_o));
         if (bp) begin
            ready_i = pat[k % 6];
            k++;
         end
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got no done pulse expected one", name);
      end
   endtask

   initial begin
      int d0, b0, v0, h0;
      bit got2;
      for (int i = 0; i < DEPTH; i++) rom[i] = WIDTH'(8'h10 + i);
      rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; length_i = '0; ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_valid", int'(valid_o), 0);
      check("rst_last", int'(last_o), 0);
      check("rst_data", int'(data_o), 0);
      check("rst_addr", int'(rom_addr_o), 0);
      @(negedge clk) rst_n = 1'b1;

      // Basic run: 13,14,15,16 back to back
      d0 = done_cnt;
      start_xfer(3, 4);
      wait_done("t1", d0, 1'b0);
      check("t1_first_valid_lat", first_valid_cyc - start_cyc, 2);
      check("t1_burst_span", last_hs_cyc - first_hs_cyc, 3);
      check("t1_done_after_last", done_cyc - last_hs_cyc, 1);
      check("t1_done_count", done_cnt - d0, 1);
      check("t1_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);

      // Wrap-around addresses
      d0 = done_cnt;
      start_xfer(14, 4);
      wait_done("t2", d0, 1'b0);
      check("t2_addr_count", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         check("t2_addr0", addr_log[0], 14);
         check("t2_addr1", addr_log[1], 15);
         check("t2_addr2", addr_log[2], 0);
         check("t2_addr3", addr_log[3], 1);
      end
      check("t2_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);

      // Backpressure
      d0 = done_cnt; h0 = hs_cnt;
      start_xfer(5, 6);
      wait_done("t3", d0, 1'b1);
      check("t3_words", hs_cnt - h0, 6);
      check("t3_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);

      // Zero length, second start during busy ignored
      d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
      @(posedge clk); #1;
      start_i = 1'b1; base_addr_i = 4'd2; length_i = 5'd0;
      @(posedge clk); #1;
      length_i = 5'd3;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("t4_done_count", done_cnt - d0, 1);
      check("t4_busy_cycles", busy_cnt - b0, 1);
      check("t4_no_valid", valid_cnt - v0, 0);

      // Full ROM sweep
      d0 = done_cnt; h0 = hs_cnt;
      start_xfer(0, 16);
      wait_done("t5", d0, 1'b0);
      check("t5_words", hs_cnt - h0, 16);
      check("t5_burst_span", last_hs_cyc - first_hs_cyc, 15);
      check("t5_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);

      // Reset mid-transfer, then a clean restart
      d0 = done_cnt; h0 = hs_cnt;
      start_xfer(0, 8);
      got2 = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (hs_cnt - h0 >= 2) begin
            got2 = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("t6_two_words_seen", int'(got2), 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", int'(busy_o), 0);
      check("t6_rst_valid", int'(valid_o), 0);
      check("t6_rst_data", int'(data_o), 0);
      check("t6_rst_addr", int'(rom_addr_o), 0);
      check("t6_rst_last", int'(last_o), 0);
      check("t6_rst_state", int'(dut.state_q), int'(IDLE));
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      check("t6_no_done_on_abort", done_cnt - d0, 0);
      d0 = done_cnt; h0 = hs_cnt;
      start_xfer(0, 2);
      wait_done("t6", d0, 1'b0);
      check("t6_words", hs_cnt - h0, 2);
      check("t6_drained", exp_q.size(), 0);

      check("fifo_never_overflows", int'(max_cnt <= 2), 1);
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/convolutor_rom_reader.md
Name: convolutor_rom_reader

Overview:
- Read-side sequencer for the single-port synchronous ROM (1-cycle registered read latency).
- On a start command it fetches `length_i` consecutive words from `base_addr_i`, wrapping modulo DEPTH.
- It streams the words out on a valid/ready interface with full backpressure support.
- It sits between the coefficient ROM and the convolution datapath, and hides the ROM read latency behind a 2-entry buffer.

Parameters:
- WIDTH, 8, ROM word size in bits.
- DEPTH, 16, ROM words; power of 2.
- ADDRW, $clog2(DEPTH), address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  start request; sampled only in IDLE.
- base_addr_i  input  ADDRW  first ROM address; captured on accepted start.
- length_i  input  ADDRW+1  words to fetch, 0..DEPTH; captured on accepted start.
- busy_o  output  1  high from accepted start until done_o.
- done_o  output  1  one-cycle completion pulse.
- rom_addr_o  output  ADDRW  drives ROM read_address_i.
- rom_data_i  input  WIDTH  from ROM read_data_o.
- data_o  output  WIDTH  stream data.
- valid_o  output  1  stream valid.
- ready_i  input  1  stream ready.
- last_o  output  1  high with the final word of a transfer.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - busy_o=0, done_o=0, valid_o=0, last_o=0.
  - data_o=0, rom_addr_o=0.
  - Buffer empty, in-flight flag cleared, counters 0.
- Reset mid-transfer aborts the transfer with no done_o pulse. Words in flight are discarded.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start_i=1 with length_i>0 → capture base and length, go to FETCH, busy_o=1 next cycle.
  - start_i=1 with length_i=0 → go to DONE, with busy_o=1 for that one cycle. No data is emitted.
- FETCH:
  - A read is issued in a cycle when issue_cnt<length and credit is available.
  - Issuing a read means rom_addr_o=(base+issue_cnt) mod DEPTH is presented, and the in-flight flag is set for the next cycle.
  - Credit rule: buf_count + inflight < 2, or buf_count + inflight == 2 and a pop (valid_o & ready_i) occurs this cycle.
  - When issue_cnt reaches length → DRAIN.
- rom_addr_o holds its last value when no read is issued.
- Capture: in the cycle after an issue, rom_data_i is written into the 2-entry FIFO. A push and a pop in the same cycle are both honoured, and the count is unchanged.
- Overflow is impossible by the credit rule. The bench asserts this.
- Stream output:
  - data_o and valid_o come from the FIFO head and are registered (no combinational path from rom_data_i).
  - data_o and last_o hold stable while valid_o=1 and ready_i=0.
  - last_o=1 only when the head is word index length-1.
- DRAIN: when out_cnt==length (the last handshake has completed) → DONE.
- DONE:
  - done_o=1 and busy_o=1 for exactly one cycle, then IDLE.
  - busy_o=0 from the IDLE cycle onward.
- start_i is ignored in FETCH, DRAIN and DONE.
- Latency: start accepted at edge E0 → first address during cycle after E0 → ROM registers at E1 → FIFO write at E2 → valid_o=1 in the cycle after E2.
- Throughput: with ready_i held high, 1 word/cycle sustained after the first word.
- Wrap-around: base=DEPTH-2, length=4 reads addresses DEPTH-2, DEPTH-1, 0, 1.
- length=DEPTH reads every word exactly once.
- Counters are ADDRW+1 bits wide. The address sum truncates to ADDRW bits.

Decomposition:
- Package convolutor_rom_reader_pkg:
  - typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} rd_state_t.
  - localparam BUF_DEPTH=2.
- Sub-module convolutor_skid_fifo:
  - Parameter WIDTH; fixed 2 entries.
  - Ports: push, push data, pop, head data, count.
  - Reset via rst_n.

Test Plan:
- ROM preloaded with rom[i]=8'h10+i. base=3, length=4, ready_i=1 → data_o sequence 13,14,15,16 on 4 consecutive cycles, with valid_o first in the 3rd cycle after start. last_o with 16. done_o pulses 1 cycle after the 16 handshake.
- base=14, length=4, DEPTH=16 → rom_addr_o sequence 14,15,0,1; data 1E,1F,10,11.
- Backpressure: length=6, ready_i toggles 1,0,0,1,0,1,… → all six words delivered in order, none lost or duplicated. data_o is stable whenever valid_o=1 and ready_i=0, and FIFO count never exceeds 2.
- length=0 → busy_o for 1 cycle, done_o pulse, valid_o never asserted. A second start during busy is ignored; only one done_o pulse.
- length=16, ready_i=1 → 16 words in 16 consecutive cycles, all ROM entries once, last_o only on the 16th.
- rst_n asserted mid-transfer (after 2 of 8 words) → all outputs 0 immediately and state IDLE. A new start afterward (base=0, length=2) returns 10,11 correctly.
